// File: rtl/irq_ctrl_if.sv
// -----------------------------------------------------------------------------
// irq_ctrl_if -- register access bus for the interrupt controller.
//
// Signals:
//   sel    access strobe, at most one access per cycle
//   we     1 = write, 0 = read (only meaningful while sel=1)
//   addr   register select: 0 PEND, 1 MASK, 2 EDGE, 3 CLAIM
//   wdata  write data
//   rdata  read data, driven combinationally by the controller
//
// Modports:
//   master  bus initiator (CPU side / testbench)
//   slave   the controller
// -----------------------------------------------------------------------------
interface irq_ctrl_if;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output sel, output we, output addr, output wdata, input rdata);
    modport slave  (input sel, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl -- prioritised interrupt controller with claim / end-of-interrupt.
//
// Each source is either level-sensitive (pending follows the raw line) or
// rising-edge triggered (pending is held in an edge latch until cleared by a
// PEND write or by a claim). Enabled pending sources compete on fixed
// priority, index 0 highest. A CLAIM read hands the winner to software and
// suppresses irq until the matching id is written back to CLAIM (EOI).
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   src_i     raw interrupt lines, synchronous to clk
//   bus       register access bus (irq_ctrl_if.slave)
//   irq_o     registered interrupt request
//   irq_id_o  registered index of the highest-priority enabled pending source
// -----------------------------------------------------------------------------
module irq_ctrl #(
    parameter int N_SRC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_i,
    irq_ctrl_if.slave        bus,
    output logic             irq_o,
    output logic [4:0]       irq_id_o
);

    localparam logic [1:0] A_PEND  = 2'd0;
    localparam logic [1:0] A_MASK  = 2'd1;
    localparam logic [1:0] A_EDGE  = 2'd2;
    localparam logic [1:0] A_CLAIM = 2'd3;

    typedef enum logic {IDLE, BUSY} state_t;

    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] edge_q, edge_d;
    logic [N_SRC-1:0] lat_q,  lat_d;
    logic [N_SRC-1:0] src_q;

    state_t     state_q;
    logic [4:0] claimed_id_q;
    logic       irq_q;
    logic [4:0] irq_id_q;

    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] cand;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] wdata_n;
    logic [4:0]       winner;
    logic             has_cand;
    logic             wr_pend, wr_mask, wr_edge, wr_claim, rd_claim;
    logic             claim_take, eoi;

    function automatic logic [4:0] lowest_set(input logic [N_SRC-1:0] v);
        logic [4:0] r;
        r = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) r = 5'(i);
        end
        return r;
    endfunction

    assign wdata_n  = bus.wdata[N_SRC-1:0];
    assign wr_pend  = bus.sel &&  bus.we && (bus.addr == A_PEND);
    assign wr_mask  = bus.sel &&  bus.we && (bus.addr == A_MASK);
    assign wr_edge  = bus.sel &&  bus.we && (bus.addr == A_EDGE);
    assign wr_claim = bus.sel &&  bus.we && (bus.addr == A_CLAIM);
    assign rd_claim = bus.sel && !bus.we && (bus.addr == A_CLAIM);

    // Edge-mode bits come from the latch, level-mode bits straight from the pin.
    assign pend     = (edge_q & lat_q) | (~edge_q & src_i);
    assign cand     = pend & mask_q;
    assign has_cand = |cand;
    assign winner   = lowest_set(cand);
    assign rise     = edge_q & src_i & ~src_q;

    // The claim uses the live candidate, not the registered irq_id.
    assign claim_take = rd_claim && (state_q == IDLE) && has_cand;
    assign eoi        = wr_claim && (state_q == BUSY) && (bus.wdata[4:0] == claimed_id_q);

    always_comb begin
        clr = '0;
        if (wr_pend) clr = clr | wdata_n;
        // Switching a source into edge mode discards any stale latch content.
        if (wr_edge) clr = clr | (wdata_n & ~edge_q);
        if (claim_take) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (winner == 5'(i)) clr[i] = 1'b1;
            end
        end
        // A new edge in the same cycle wins over any clear.
        lat_d  = (lat_q & ~clr) | rise;
        mask_d = wr_mask ? wdata_n : mask_q;
        edge_d = wr_edge ? wdata_n : edge_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= '0;
            edge_q <= '0;
            lat_q  <= '0;
            src_q  <= '0;
        end else begin
            mask_q <= mask_d;
            edge_q <= edge_d;
            lat_q  <= lat_d;
            src_q  <= src_i;
        end
    end

    // Claim FSM with registered irq / irq_id outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            claimed_id_q <= '0;
            irq_q        <= 1'b0;
            irq_id_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (claim_take) begin
                        state_q      <= BUSY;
                        claimed_id_q <= winner;
                        irq_q        <= 1'b0;
                        irq_id_q     <= winner;
                    end else begin
                        irq_q        <= has_cand;
                        irq_id_q     <= winner;
                    end
                end
                BUSY: begin
                    irq_q    <= 1'b0;
                    irq_id_q <= claimed_id_q;
                    if (eoi) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign irq_o    = irq_q;
    assign irq_id_o = irq_id_q;

    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            A_PEND: bus.rdata[N_SRC-1:0] = pend;
            A_MASK: bus.rdata[N_SRC-1:0] = mask_q;
            A_EDGE: bus.rdata[N_SRC-1:0] = edge_q;
            A_CLAIM: begin
                if (state_q == BUSY) begin
                    bus.rdata[4:0] = claimed_id_q;
                end else if (has_cand) begin
                    bus.rdata[31]  = 1'b1;
                    bus.rdata[4:0] = winner;
                end
            end
            default: bus.rdata = '0;
        endcase
    end

endmodule
